// File: rtl/mult_wb_unit.sv
// -----------------------------------------------------------------------------
// mult_wb_unit
//   Iterative integer multiplier for MUL instructions in the EX stage.
//   Consumes BITS_PER_CYCLE bits of the multiplier per cycle and keeps the low
//   DATA_W bits of the product. The registered result drives the register
//   file write port directly, so every output is zero outside the DONE cycle
//   (the register file bypasses wdata on a waddr match, and x0 must read 0).
//
// Ports
//   clk        in   1       system clock, rising edge
//   arst_n     in   1       asynchronous reset, active low
//   start      in   1       request a multiply; accepted only when busy==0
//   flush      in   1       synchronous abort, priority over start
//   op_a       in   DATA_W  multiplicand
//   op_b       in   DATA_W  multiplier
//   dest_in    in   5       destination register index
//   busy       out  1       operation in progress; start ignored while high
//   done       out  1       one-cycle pulse when result is valid
//   result     out  DATA_W  product[DATA_W-1:0] (register file wdata)
//   waddr      out  5       destination index (register file waddr)
//   reg_write  out  1       register file write enable
//
// Handshake: start is a request qualified by !busy; a request seen while busy
// is dropped, never queued. done/reg_write are single-cycle strobes with no
// back-pressure: the consumer must take the write in that cycle.
//
// The FSM state is visible as the signal `state` (type mult_state_e).
// -----------------------------------------------------------------------------
module mult_wb_unit #(
  parameter int DATA_W         = 16,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [4:0]        dest_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [4:0]        waddr,
  output logic              reg_write
);

  localparam int N_ITER = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  mult_state_e state, state_next;

  logic [DATA_W-1:0] a_sh;
  logic [DATA_W-1:0] b_sh;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;
  logic [DATA_W-1:0] b_digit;
  logic [4:0]        dest;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              last_iter;

  // A new operation can start from IDLE or from DONE (retiring the old one on
  // the same edge); flush always wins.
  assign accept    = start && !flush && (state != RUN);
  assign last_iter = (state == RUN) && (cnt == CNT_LAST);

  // Zero-extended low digit of the multiplier; the product is truncated to
  // DATA_W bits, which is sign-agnostic for the low half.
  assign b_digit  = {{(DATA_W-BITS_PER_CYCLE){1'b0}}, b_sh[BITS_PER_CYCLE-1:0]};
  assign acc_next = acc + (a_sh * b_digit);

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = RUN;
        RUN:     if (last_iter) state_next = DONE;
        DONE:    state_next = accept ? RUN : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      dest      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      waddr     <= '0;
      reg_write <= 1'b0;
    end else begin
      state     <= state_next;
      // Write-port outputs are strobes: cleared every cycle unless retiring.
      done      <= 1'b0;
      reg_write <= 1'b0;
      result    <= '0;
      waddr     <= '0;
      if (flush) begin
        busy <= 1'b0;
      end else if (accept) begin
        a_sh <= op_a;
        b_sh <= op_b;
        dest <= dest_in;
        acc  <= '0;
        cnt  <= '0;
        busy <= 1'b1;
      end else if (state == RUN) begin
        acc  <= acc_next;
        a_sh <= a_sh << BITS_PER_CYCLE;
        b_sh <= b_sh >> BITS_PER_CYCLE;
        cnt  <= cnt + 1'b1;
        if (last_iter) begin
          busy <= 1'b0;
          done <= 1'b1;
          // Writes to x0 are suppressed entirely so the bypass never sees a
          // nonzero value for register 0.
          if (dest != 5'd0) begin
            result    <= acc_next;
            waddr     <= dest;
            reg_write <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_wb_unit.sv
module tb_mult_wb_unit;

  localparam int W = 16;

  logic         clk;
  logic         arst_n;
  logic         start;
  logic         flush;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [4:0]   dest_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [4:0]   waddr;
  logic         reg_write;

  int n_checks;
  int n_fail;

  mult_wb_unit #(.DATA_W(W), .BITS_PER_CYCLE(4)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .start     (start),
    .flush     (flush),
    .op_a      (op_a),
    .op_b      (op_b),
    .dest_in   (dest_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .waddr     (waddr),
    .reg_write (reg_write)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Checks all write-port outputs in one go.
  task automatic check_out(input string tag, input logic b, input logic d,
                           input logic [W-1:0] r, input logic [4:0] wa, input logic we);
    check({tag, ".busy"},      {31'd0, busy},      {31'd0, b});
    check({tag, ".done"},      {31'd0, done},      {31'd0, d});
    check({tag, ".result"},    {16'd0, result},    {16'd0, r});
    check({tag, ".waddr"},     {27'd0, waddr},     {27'd0, wa});
    check({tag, ".reg_write"}, {31'd0, reg_write}, {31'd0, we});
  endtask

  // Single operation: start for one cycle, 4 busy cycles, one DONE cycle,
  // then idle with zeroed outputs.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] d, input logic [W-1:0] exp_r);
    logic we;
    we = (d != 5'd0);
    @(negedge clk);
    op_a = a; op_b = b; dest_in = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom_range(0, 16'hFFFF);
    op_b = $urandom_range(0, 16'hFFFF);
    dest_in = 5'($urandom_range(0, 31));
    for (int i = 0; i < 4; i++) begin
      check_out({tag, ".run"}, 1'b1, 1'b0, '0, 5'd0, 1'b0);
      @(negedge clk);
    end
    check_out({tag, ".done"}, 1'b0, 1'b1, we ? exp_r : '0, we ? d : 5'd0, we);
    @(negedge clk);
    check_out({tag, ".idle"}, 1'b0, 1'b0, '0, 5'd0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    arst_n   = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    op_a     = '0;
    op_b     = '0;
    dest_in  = '0;
    repeat (3) @(negedge clk);
    check_out("reset", 1'b0, 1'b0, '0, 5'd0, 1'b0);
    arst_n = 1'b1;
    @(negedge clk);
    check_out("post_reset", 1'b0, 1'b0, '0, 5'd0, 1'b0);

    // basic and wrap-around products
    run_op("mul3x5", 16'd3, 16'd5, 5'd7, 16'd15);
    run_op("mul1234", 16'h1234, 16'h0100, 5'd9, 16'h3400);
    run_op("mulffff", 16'hFFFF, 16'hFFFF, 5'd31, 16'h0001);
    run_op("mul_digits", 16'h0007, 16'h1111, 5'd2, 16'h7777);
    // x0 destination: no write, outputs stay zero
    run_op("x0", 16'd2, 16'd2, 5'd0, 16'd4);

    // start held for 10 cycles with changing operands: op j uses
    // a=j+2, b=j+3, dest=j+1. Accepts at edges 0 and 5 -> 2*3=6 to x1,
    // 7*8=56 to x6.
    for (int j = 0; j <= 11; j++) begin
      @(negedge clk);
      if (j >= 1) begin
        if (j == 5)
          check_out("hold.done1", 1'b0, 1'b1, 16'd6, 5'd1, 1'b1);
        else if (j == 10)
          check_out("hold.done2", 1'b0, 1'b1, 16'd56, 5'd6, 1'b1);
        else if (j == 11)
          check_out("hold.idle", 1'b0, 1'b0, '0, 5'd0, 1'b0);
        else
          check_out("hold.run", 1'b1, 1'b0, '0, 5'd0, 1'b0);
      end
      start   = (j <= 9);
      op_a    = W'(j + 2);
      op_b    = W'(j + 3);
      dest_in = 5'(j + 1);
    end
    start = 1'b0;

    // flush during RUN: back to idle, no write ever appears
    @(negedge clk);
    op_a = 16'd9; op_b = 16'd9; dest_in = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_out("flush_run", 1'b0, 1'b0, '0, 5'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_out("flush_after", 1'b0, 1'b0, '0, 5'd0, 1'b0);
    end

    // flush + start in IDLE: nothing accepted
    op_a = 16'd5; op_b = 16'd5; dest_in = 5'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check_out("flush_start", 1'b0, 1'b0, '0, 5'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_out("flush_start_after", 1'b0, 1'b0, '0, 5'd0, 1'b0);
    end

    // flush in DONE: presented write stays for its cycle, then clears
    @(negedge clk);
    op_a = 16'd11; op_b = 16'd3; dest_in = 5'd12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_out("flush_done.present", 1'b0, 1'b1, 16'd33, 5'd12, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_out("flush_done.clear", 1'b0, 1'b0, '0, 5'd0, 1'b0);

    // async reset mid-RUN
    @(negedge clk);
    op_a = 16'd100; op_b = 16'd100; dest_in = 5'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("arst.busy_before", {31'd0, busy}, 32'd1);
    #2 arst_n = 1'b0;
    #1 check_out("arst.immediate", 1'b0, 1'b0, '0, 5'd0, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_out("arst.after", 1'b0, 1'b0, '0, 5'd0, 1'b0);
    end
    run_op("mul6x7", 16'd6, 16'd7, 5'd3, 16'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
